// File: rtl/e_m_pipe_reg.sv
// E->M pipeline register.
// Picks the E-stage result (ALU or HI/LO read data), latches it together with
// its control fields for the M stage, and supports hold, bubble insertion and
// Tnew countdown for the hazard unit. It also keeps two free-running
// performance counters: stall cycles and bubbles taken.
module e_m_pipe_reg #(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5,
    parameter int unsigned TW = 2,
    parameter int unsigned CW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          flush,
    input  logic [DW-1:0] E_PC,
    input  logic [DW-1:0] E_Instr,
    input  logic [DW-1:0] E_ALUOut,
    input  logic [DW-1:0] E_HILOOut,
    input  logic          E_HILOSel,
    input  logic [DW-1:0] E_rtData,
    input  logic [RW-1:0] E_RegAddr,
    input  logic          E_RegWE,
    input  logic          E_MemWE,
    input  logic [TW-1:0] E_Tnew,
    output logic [DW-1:0] M_PC,
    output logic [DW-1:0] M_Instr,
    output logic [DW-1:0] M_Result,
    output logic [DW-1:0] M_rtData,
    output logic [RW-1:0] M_RegAddr,
    output logic          M_RegWE,
    output logic          M_MemWE,
    output logic [TW-1:0] M_Tnew,
    output logic          M_Valid,
    output logic          M_FwdValid,
    output logic [CW-1:0] StallCnt,
    output logic [CW-1:0] BubbleCnt
);

    // Pipeline payload state and its next-state values.
    logic [DW-1:0] pc_q,       pc_d;
    logic [DW-1:0] instr_q,    instr_d;
    logic [DW-1:0] result_q,   result_d;
    logic [DW-1:0] rt_data_q,  rt_data_d;
    logic [RW-1:0] reg_addr_q, reg_addr_d;
    logic          reg_we_q,   reg_we_d;
    logic          mem_we_q,   mem_we_d;
    logic [TW-1:0] tnew_q,     tnew_d;
    logic          valid_q,    valid_d;

    // Performance counters.
    logic [CW-1:0] stall_cnt_q,  stall_cnt_d;
    logic [CW-1:0] bubble_cnt_q, bubble_cnt_d;

    // Result select and capture-time qualifiers for an advancing instruction.
    logic [DW-1:0] e_result;
    logic          e_reg_we;
    logic [TW-1:0] e_tnew_dec;

    // Select the E-stage result and derive the M-stage control values.
    always_comb begin
        e_result   = E_HILOSel ? E_HILOOut : E_ALUOut;
        // A write to $0 is never architecturally visible; drop it here so
        // the forwarding logic downstream never sees it.
        e_reg_we   = E_RegWE & (E_RegAddr != RW'(0));
        // Tnew counts down by one per stage and saturates at zero.
        e_tnew_dec = (E_Tnew == TW'(0)) ? TW'(0) : E_Tnew - TW'(1);
    end

    // Next-state logic: flush beats hold, and hold beats advance.
    always_comb begin
        pc_d         = pc_q;
        instr_d      = instr_q;
        result_d     = result_q;
        rt_data_d    = rt_data_q;
        reg_addr_d   = reg_addr_q;
        reg_we_d     = reg_we_q;
        mem_we_d     = mem_we_q;
        tnew_d       = tnew_q;
        valid_d      = valid_q;
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;

        if (flush) begin
            // The bubble keeps the PC so exception and debug logic can
            // still tell where the slot came from.
            pc_d         = E_PC;
            instr_d      = DW'(0);
            result_d     = DW'(0);
            rt_data_d    = DW'(0);
            reg_addr_d   = RW'(0);
            reg_we_d     = 1'b0;
            mem_we_d     = 1'b0;
            tnew_d       = TW'(0);
            valid_d      = 1'b0;
            bubble_cnt_d = bubble_cnt_q + CW'(1);
        end else if (!en) begin
            stall_cnt_d  = stall_cnt_q + CW'(1);
        end else begin
            pc_d         = E_PC;
            instr_d      = E_Instr;
            result_d     = e_result;
            rt_data_d    = E_rtData;
            reg_addr_d   = E_RegAddr;
            reg_we_d     = e_reg_we;
            mem_we_d     = E_MemWE;
            tnew_d       = e_tnew_dec;
            valid_d      = 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q         <= DW'(0);
            instr_q      <= DW'(0);
            result_q     <= DW'(0);
            rt_data_q    <= DW'(0);
            reg_addr_q   <= RW'(0);
            reg_we_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            tnew_q       <= TW'(0);
            valid_q      <= 1'b0;
            stall_cnt_q  <= CW'(0);
            bubble_cnt_q <= CW'(0);
        end else begin
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            result_q     <= result_d;
            rt_data_q    <= rt_data_d;
            reg_addr_q   <= reg_addr_d;
            reg_we_q     <= reg_we_d;
            mem_we_q     <= mem_we_d;
            tnew_q       <= tnew_d;
            valid_q      <= valid_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    // Outputs come straight from registers; the forward-valid flag decodes
    // registered state only, so no input reaches an output in the same cycle.
    always_comb begin
        M_PC       = pc_q;
        M_Instr    = instr_q;
        M_Result   = result_q;
        M_rtData   = rt_data_q;
        M_RegAddr  = reg_addr_q;
        M_RegWE    = reg_we_q;
        M_MemWE    = mem_we_q;
        M_Tnew     = tnew_q;
        M_Valid    = valid_q;
        M_FwdValid = valid_q & reg_we_q & (tnew_q == TW'(0));
        StallCnt   = stall_cnt_q;
        BubbleCnt  = bubble_cnt_q;
    end

endmodule

// File: tb/tb_e_m_pipe_reg.sv
// Directed bench for e_m_pipe_reg. A second instance with a 4-bit counter
// width shares the stimulus so counter wrap is reachable in a few cycles.
module tb_e_m_pipe_reg;

    logic        clk = 1'b0;
    logic        reset, en, flush;
    logic [31:0] E_PC, E_Instr, E_ALUOut, E_HILOOut, E_rtData;
    logic        E_HILOSel, E_RegWE, E_MemWE;
    logic [4:0]  E_RegAddr;
    logic [1:0]  E_Tnew;

    logic [31:0] M_PC, M_Instr, M_Result, M_rtData, StallCnt, BubbleCnt;
    logic [4:0]  M_RegAddr;
    logic        M_RegWE, M_MemWE, M_Valid, M_FwdValid;
    logic [1:0]  M_Tnew;

    logic [31:0] w_PC, w_Instr, w_Result, w_rtData;
    logic [4:0]  w_RegAddr;
    logic        w_RegWE, w_MemWE, w_Valid, w_FwdValid;
    logic [1:0]  w_Tnew;
    logic [3:0]  w_StallCnt, w_BubbleCnt;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    longint unsigned exp_stall = 0;
    longint unsigned exp_bub   = 0;

    always #5 clk = ~clk;

    e_m_pipe_reg dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .E_PC(E_PC), .E_Instr(E_Instr), .E_ALUOut(E_ALUOut),
        .E_HILOOut(E_HILOOut), .E_HILOSel(E_HILOSel), .E_rtData(E_rtData),
        .E_RegAddr(E_RegAddr), .E_RegWE(E_RegWE), .E_MemWE(E_MemWE),
        .E_Tnew(E_Tnew),
        .M_PC(M_PC), .M_Instr(M_Instr), .M_Result(M_Result),
        .M_rtData(M_rtData), .M_RegAddr(M_RegAddr), .M_RegWE(M_RegWE),
        .M_MemWE(M_MemWE), .M_Tnew(M_Tnew), .M_Valid(M_Valid),
        .M_FwdValid(M_FwdValid), .StallCnt(StallCnt), .BubbleCnt(BubbleCnt)
    );

    e_m_pipe_reg #(.CW(4)) dut_w (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .E_PC(E_PC), .E_Instr(E_Instr), .E_ALUOut(E_ALUOut),
        .E_HILOOut(E_HILOOut), .E_HILOSel(E_HILOSel), .E_rtData(E_rtData),
        .E_RegAddr(E_RegAddr), .E_RegWE(E_RegWE), .E_MemWE(E_MemWE),
        .E_Tnew(E_Tnew),
        .M_PC(w_PC), .M_Instr(w_Instr), .M_Result(w_Result),
        .M_rtData(w_rtData), .M_RegAddr(w_RegAddr), .M_RegWE(w_RegWE),
        .M_MemWE(w_MemWE), .M_Tnew(w_Tnew), .M_Valid(w_Valid),
        .M_FwdValid(w_FwdValid), .StallCnt(w_StallCnt), .BubbleCnt(w_BubbleCnt)
    );

    // Single comparison point: count it, report any miscompare.
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock; update the expected counters from the applied controls.
    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            exp_stall = 0;
            exp_bub   = 0;
        end else if (flush) begin
            exp_bub++;
        end else if (!en) begin
            exp_stall++;
        end
        #1;
    endtask

    task automatic set_e(input logic [31:0] pc, input logic [31:0] instr,
                         input logic [31:0] alu, input logic [31:0] hilo,
                         input logic sel, input logic [31:0] rt,
                         input logic [4:0] ra, input logic rwe,
                         input logic mwe, input logic [1:0] tn);
        E_PC = pc; E_Instr = instr; E_ALUOut = alu; E_HILOOut = hilo;
        E_HILOSel = sel; E_rtData = rt; E_RegAddr = ra; E_RegWE = rwe;
        E_MemWE = mwe; E_Tnew = tn;
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_stall"},   64'(StallCnt),    64'(exp_stall));
        chk({tag, "_bubble"},  64'(BubbleCnt),   64'(exp_bub));
        chk({tag, "_stall_w"}, 64'(w_StallCnt),  64'(exp_stall % 16));
    endtask

    initial begin
        reset = 1'b0; en = 1'b1; flush = 1'b0;
        set_e($urandom, $urandom, $urandom, $urandom, 1'b1, $urandom,
              5'd7, 1'b1, 1'b1, 2'd2);
        tick();
        set_e($urandom, $urandom, $urandom, $urandom, 1'b0, $urandom,
              5'd9, 1'b1, 1'b1, 2'd0);
        tick();
        // Reset state
        chk("rst_pc",     64'(M_PC), 0);
        chk("rst_instr",  64'(M_Instr), 0);
        chk("rst_result", 64'(M_Result), 0);
        chk("rst_rt",     64'(M_rtData), 0);
        chk("rst_ra",     64'(M_RegAddr), 0);
        chk("rst_ctl",    64'({M_RegWE, M_MemWE, M_Tnew, M_Valid, M_FwdValid}), 0);
        chk_cnt("rst");

        // HI/LO select, Tnew 2 -> 1
        reset = 1'b1;
        set_e(32'h0000_1000, 32'h0000_AAAA, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1,
              32'h0000_0055, 5'd3, 1'b1, 1'b0, 2'd2);
        tick();
        chk("hilo_result", 64'(M_Result), 64'h1234_5678);
        chk("hilo_tnew",   64'(M_Tnew), 1);
        chk("hilo_valid",  64'(M_Valid), 1);
        chk("hilo_fwd",    64'(M_FwdValid), 0);
        chk("hilo_pc",     64'(M_PC), 64'h1000);
        chk("hilo_instr",  64'(M_Instr), 64'hAAAA);
        chk("hilo_rt",     64'(M_rtData), 64'h55);
        chk("hilo_ra_we",  64'({M_RegAddr, M_RegWE, M_MemWE}), 64'({5'd3, 1'b1, 1'b0}));

        // HI/LO changes while held: captured result must not move
        en = 1'b0;
        E_HILOOut = 32'h0BAD_F00D;
        tick();
        chk("hold_hilo_result", 64'(M_Result), 64'h1234_5678);
        chk_cnt("hold_hilo");

        // ALU select, write to $0 dropped
        en = 1'b1;
        set_e(32'h0000_1004, 32'h0000_BBBB, 32'hCAFE_F00D, 32'h1111_1111, 1'b0,
              32'h0000_0066, 5'd0, 1'b1, 1'b1, 2'd0);
        tick();
        chk("r0_result", 64'(M_Result), 64'hCAFE_F00D);
        chk("r0_regwe",  64'(M_RegWE), 0);
        chk("r0_fwd",    64'(M_FwdValid), 0);
        chk("r0_memwe",  64'(M_MemWE), 1);

        // Tnew 0 to $5 -> forwardable
        set_e(32'h0000_1008, 32'h0000_CCCC, 32'h0000_0042, 32'h0, 1'b0,
              32'h0, 5'd5, 1'b1, 1'b0, 2'd0);
        tick();
        chk("r5_fwd",  64'(M_FwdValid), 1);
        chk("r5_tnew", 64'(M_Tnew), 0);

        // Tnew countdown 3 -> 2 and 1 -> 0
        E_Tnew = 2'd3;
        tick();
        chk("t3_tnew", 64'(M_Tnew), 2);
        chk("t3_fwd",  64'(M_FwdValid), 0);
        E_Tnew = 2'd1;
        tick();
        chk("t1_tnew", 64'(M_Tnew), 0);
        chk("t1_fwd",  64'(M_FwdValid), 1);

        // Capture, then hold 3 cycles with changing inputs
        set_e(32'h0000_2000, 32'h0000_DDDD, 32'h7777_0000, 32'h0, 1'b0,
              32'h0000_0099, 5'd12, 1'b1, 1'b1, 2'd1);
        tick();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_e($urandom, $urandom, $urandom, $urandom, 1'b1, $urandom,
                  5'd31, 1'b0, 1'b0, 2'd3);
            tick();
        end
        chk("hold3_pc",     64'(M_PC), 64'h2000);
        chk("hold3_result", 64'(M_Result), 64'h7777_0000);
        chk("hold3_ctl",    64'({M_RegAddr, M_RegWE, M_MemWE, M_Tnew, M_Valid}),
                            64'({5'd12, 1'b1, 1'b1, 2'd0, 1'b1}));
        chk("hold3_stall",  64'(StallCnt), 4);
        chk_cnt("hold3");

        // Flush with en=0: bubble keeps PC, stall count frozen
        set_e(32'h0000_3000, 32'h0000_EEEE, 32'h1, 32'h2, 1'b0, 32'h3,
              5'd8, 1'b1, 1'b1, 2'd0);
        flush = 1'b1;
        tick();
        chk("flush_pc",     64'(M_PC), 64'h3000);
        chk("flush_ctl",    64'({M_Valid, M_RegWE, M_MemWE, M_FwdValid}), 0);
        chk("flush_pay",    64'({M_Instr, M_Result}), 0);
        chk("flush_bubble", 64'(BubbleCnt), 1);
        chk("flush_stall",  64'(StallCnt), 4);
        // Flush with en=1 still inserts a bubble
        en = 1'b1;
        tick();
        chk("flush_en_valid", 64'(M_Valid), 0);
        chk_cnt("flush_en");

        // Drive the narrow counter to all-ones, then one more stall wraps it
        flush = 1'b0;
        en = 1'b0;
        for (int i = 0; i < 16 && exp_stall[3:0] != 4'hF; i++) tick();
        chk("wrap_pre",  64'(w_StallCnt), 64'hF);
        tick();
        chk("wrap_post", 64'(w_StallCnt), 0);
        chk_cnt("wrap");

        // Reset during a stall clears counters the same cycle
        reset = 1'b0;
        tick();
        chk("rst_stall_cnts", 64'({StallCnt, BubbleCnt}), 0);
        chk("rst_stall_w",    64'({w_StallCnt, w_BubbleCnt}), 0);
        // Reset during a flush wins over the flush
        reset = 1'b1;
        flush = 1'b1;
        tick();
        chk("pre_rflush_bubble", 64'(BubbleCnt), 1);
        reset = 1'b0;
        tick();
        chk("rst_flush_cnts", 64'({StallCnt, BubbleCnt}), 0);
        chk("rst_flush_pc",   64'(M_PC), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
